// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, slot decode type and pixel type
package vga_pkg;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 525;
   localparam int PIX_LAT  = 3;
   localparam int DW       = 8;
   typedef enum logic [1:0] {DISP, HBLANK, VBLANK} slot_t;
   typedef logic [DW-1:0] pixel_t;
endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: display-side frame-buffer address generator with upscaling and frame wrap
module fb_addr_gen #(
   parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int SCALE_SHIFT = 1,
   parameter int AW          = 17
) (
   input  logic          vga_clk,
   input  logic          reset_n,
   input  logic [9:0]    hcount,
   input  logic [9:0]    vcount,
   output logic [AW-1:0] addr
);
   import vga_pkg::H_TOTAL, vga_pkg::V_TOTAL;
   localparam int         FB_W     = H_ACTIVE >> SCALE_SHIFT;
   localparam logic [9:0] SUB_MASK = 10'((1 << SCALE_SHIFT) - 1);
   logic [AW-1:0] r_line_base;
   logic [9:0]    w_col;
   logic          w_line_end, w_frame_end;
   // column follows hcount directly; a line step happens on the last active pixel of every 2^S-th line
   always_comb begin
      w_col       = hcount >> SCALE_SHIFT;
      w_line_end  = (hcount == 10'(H_ACTIVE - 1)) && (vcount < 10'(V_ACTIVE)) && ((vcount & SUB_MASK) == SUB_MASK);
      w_frame_end = (hcount == 10'(H_TOTAL - 1)) && (vcount == 10'(V_TOTAL - 1));
      addr        = r_line_base + AW'(w_col);
   end
   // line base restarts at the frame wrap and advances one FB row per scaled line group
   always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) r_line_base <= '0;
      else if (w_frame_end) r_line_base <= '0;
      else if (w_line_end) r_line_base <= r_line_base + AW'(FB_W);
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port frame-buffer RAM between display scan-out and a host port
module fb_arbiter #(
   parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int SCALE_SHIFT = 1,
   parameter int DW          = vga_pkg::DW,
   parameter bit DOUBLE_BUF  = 1'b1,
   localparam int FB_W = H_ACTIVE >> SCALE_SHIFT,
   localparam int FB_H = V_ACTIVE >> SCALE_SHIFT,
   localparam int AW   = $clog2(FB_W * FB_H)
) (
   input  logic          vga_clk,
   input  logic          reset_n,
   input  logic [9:0]    hcount,
   input  logic [9:0]    vcount,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   input  logic          swap_req,
   output logic          swap_done,
   output logic          front_sel,
   output logic [AW:0]   mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] pix_data,
   output logic          pix_valid
);
   import vga_pkg::slot_t, vga_pkg::DISP, vga_pkg::HBLANK, vga_pkg::VBLANK;
   slot_t         w_slot;
   logic          w_accept, w_in_range, w_page, w_swap_now;
   logic [AW-1:0] w_disp_addr;
   logic [AW:0]   r_mem_addr;
   logic          r_mem_we;
   logic [DW-1:0] r_mem_wdata, r_pix_data, r_rd_data;
   logic [1:0]    r_disp, r_hrd, r_rok;
   logic          r_pix_valid, r_rd_valid;
   logic          r_front_sel, r_swap_pend, r_swap_done;

   fb_addr_gen #(
      .H_ACTIVE    (H_ACTIVE),
      .V_ACTIVE    (V_ACTIVE),
      .SCALE_SHIFT (SCALE_SHIFT),
      .AW          (AW)
   ) u_addr_gen (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .hcount  (hcount),
      .vcount  (vcount),
      .addr    (w_disp_addr)
   );

   // slot state is decoded straight from the counters, so the host sees blanking the same cycle it starts
   always_comb begin
      w_slot     = (vcount >= 10'(V_ACTIVE)) ? VBLANK : (hcount >= 10'(H_ACTIVE)) ? HBLANK : DISP;
      w_accept   = req_valid && (w_slot != DISP);
      w_in_range = {1'b0, req_addr} < (AW+1)'(FB_W * FB_H);
      w_page     = DOUBLE_BUF && !r_front_sel;
      w_swap_now = DOUBLE_BUF && (w_slot == VBLANK) && (hcount == '0) && (vcount == 10'(V_ACTIVE)) && (r_swap_pend || swap_req);
   end

   assign req_ready = w_slot != DISP;
   assign mem_addr  = r_mem_addr;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;
   assign pix_data  = r_pix_data;
   assign pix_valid = r_pix_valid;
   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign front_sel = r_front_sel;
   assign swap_done = r_swap_done;

   // one RAM access per cycle: display in active slots, host only in blanking; out-of-range writes are dropped
   always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) begin
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_addr  <= (w_slot == DISP) ? {r_front_sel, w_disp_addr} : w_accept ? {w_page, req_addr} : '0;
         r_mem_we    <= w_accept && req_we && w_in_range;
         r_mem_wdata <= (w_accept && req_we && w_in_range) ? req_wdata : '0;
      end

   // tags follow each access through the RAM latency so returning data is steered to pixel or host
   always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) begin
         r_disp      <= '0;
         r_hrd       <= '0;
         r_rok       <= '0;
         r_pix_valid <= 1'b0;
         r_pix_data  <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_disp      <= {r_disp[0], w_slot == DISP};
         r_hrd       <= {r_hrd[0], w_accept && !req_we};
         r_rok       <= {r_rok[0], w_accept && !req_we && w_in_range};
         r_pix_valid <= r_disp[1];
         r_pix_data  <= r_disp[1] ? mem_rdata : '0;
         r_rd_valid  <= r_hrd[1];
         r_rd_data   <= r_rok[1] ? mem_rdata : '0;
      end

   // swap requests collapse into one pending flag, serviced at the first vertical-blank pixel
   always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) begin
         r_front_sel <= 1'b0;
         r_swap_pend <= 1'b0;
         r_swap_done <= 1'b0;
      end else begin
         r_front_sel <= r_front_sel ^ w_swap_now;
         r_swap_pend <= DOUBLE_BUF && !w_swap_now && (r_swap_pend || swap_req);
         r_swap_done <= w_swap_now;
      end
endmodule
